// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO registers: one bit per cycle, busy while in flight.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU complete at once as NOPs.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned AW    = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
`ifdef MULDIV_DIV_EN
  localparam logic [1:0] S_DIV  = 2'd2;
`endif

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             signed_op;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic             last_iter;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next, mul_res;

  // Operand magnitudes for the signed variants; unsigned ops pass through.
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign rs_mag    = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_mag    = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Shift-add step: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_res  = neg_q ? -mul_next : mul_next;

`ifdef MULDIV_DIV_EN
  logic             rneg_q, rneg_d;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [AW-1:0]    div_next;
  logic [WIDTH-1:0] div_quot, div_rem;

  // Restoring step: acc = {partial remainder, dividend bits shifting into quotient}.
  assign div_shift = acc_q[AW-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign div_quot  = div_next[WIDTH-1:0];
  assign div_rem   = div_next[AW-1:WIDTH];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = done_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
    rneg_d  = rneg_q;
`endif
    if (clk_enable) begin
      done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !busy_q) begin
            case (op)
              OP_MTHI: hi_d = rs_val;
              OP_MTLO: lo_d = rs_val;
              OP_MULT, OP_MULTU: begin
                state_d = S_MUL;
                cnt_d   = '0;
                busy_d  = 1'b1;
                acc_d   = {{WIDTH{1'b0}}, rt_mag};
                opb_d   = rs_mag;
                neg_d   = signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              end
              OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIV_EN
                if (rt_val == '0) begin
                  done_d = 1'b1;
                end else begin
                  state_d = S_DIV;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  acc_d   = {{WIDTH{1'b0}}, rs_mag};
                  opb_d   = rt_mag;
                  neg_d   = signed_op & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                  rneg_d  = signed_op & rs_val[WIDTH-1];
                end
`else
                done_d = 1'b1;
`endif
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc_d = mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) begin
            {hi_d, lo_d} = mul_res;
            state_d      = S_IDLE;
            cnt_d        = '0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          acc_d = div_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) begin
            lo_d    = neg_q ? -div_quot : div_quot;
            hi_d    = rneg_q ? -div_rem : div_rem;
            state_d = S_IDLE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MULDIV_DIV_EN
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO and latency queued at issue, checked on done.
module tb_muldiv_sequencer;
  localparam int unsigned W = 32;
  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3;
  localparam logic [2:0] DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6, RSVD = 3'd7;

  logic         clk = 1'b0;
  logic         reset, clk_enable, start;
  logic [2:0]   op;
  logic [W-1:0] rs_val, rt_val;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct { logic [W-1:0] hi; logic [W-1:0] lo; int lat; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_err = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference model: final HI/LO and done latency (-1: no done) from the architectural definition.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sp;
    logic [63:0] up;
    int q, r;
    e.hi = m_hi; e.lo = m_lo; e.lat = -1;
    case (o)
      MTHI: e.hi = a;
      MTLO: e.lo = a;
      MULT: begin sp = longint'($signed(a)) * longint'($signed(b)); {e.hi, e.lo} = 64'(sp); e.lat = 32; end
      MULTU: begin up = {32'b0, a} * {32'b0, b}; {e.hi, e.lo} = up; e.lat = 32; end
      DIV, DIVU: begin
        e.lat = 0;
`ifdef MULDIV_DIV_EN
        if (b != 0) begin
          e.lat = 32;
          if (o == DIVU) begin
            e.lo = a / b; e.hi = a % b;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000; e.hi = 32'h0;
          end else begin
            q = int'(a) / int'(b); r = int'(a) % int'(b);
            e.lo = q; e.hi = r;
          end
        end
`endif
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, output exp_t e);
    e = model(o, a, b);
    if (e.lat >= 0) sb.push_back(e);
    m_hi = e.hi; m_lo = e.lo;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit ok);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin tick(); cyc++; end
    ok = (done === 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = NOP; rs_val = '0; rt_val = '0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (hi !== '0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
    n_cmp++; if (lo !== '0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
  endtask

  task automatic test_multu();
    exp_t e, x;
    int cyc = 0, nb = 0;
    issue(MULTU, 32'hFFFF_FFFF, 32'd2, e);
    while (done !== 1'b1 && cyc < 100) begin if (busy === 1'b1) nb++; tick(); cyc++; end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL multu_timeout got done=%b want 1", done); end
    n_cmp++; if (cyc != 32) begin n_err++; $display("FAIL multu_latency got %0d want 32", cyc); end
    n_cmp++; if (nb != 32) begin n_err++; $display("FAIL multu_busy_cycles got %0d want 32", nb); end
    x = sb.pop_front();
    n_cmp++; if (hi !== x.hi) begin n_err++; $display("FAIL multu_hi got %h want %h", hi, x.hi); end
    n_cmp++; if (lo !== x.lo) begin n_err++; $display("FAIL multu_lo got %h want %h", lo, x.lo); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL multu_done_pulse got %b want 0", done); end
  endtask

  task automatic test_mult();
    exp_t e, x;
    int cyc;
    bit ok;
    issue(MULT, 32'hFFFF_FFFD, 32'd5, e);
    wait_done(100, cyc, ok);
    n_cmp++; if (!ok || cyc != 32) begin n_err++; $display("FAIL mult_latency got %0d (done=%b) want 32", cyc, done); end
    x = sb.pop_front();
    n_cmp++; if (hi !== x.hi) begin n_err++; $display("FAIL mult_hi got %h want %h", hi, x.hi); end
    n_cmp++; if (lo !== x.lo) begin n_err++; $display("FAIL mult_lo got %h want %h", lo, x.lo); end
  endtask

  task automatic test_div();
    logic [2:0]   tops [4] = '{DIV, DIVU, DIV, DIVU};
    logic [W-1:0] ta   [4] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] tb   [4] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'd16};
    exp_t e, x;
    int cyc;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      issue(tops[i], ta[i], tb[i], e);
      n_cmp++; if (busy !== (e.lat > 0)) begin n_err++; $display("FAIL div%0d_busy got %b want %b", i, busy, e.lat > 0); end
      wait_done(100, cyc, ok);
      n_cmp++; if (!ok || cyc != e.lat) begin n_err++; $display("FAIL div%0d_latency got %0d (done=%b) want %0d", i, cyc, done, e.lat); end
      x = sb.pop_front();
      n_cmp++; if (hi !== x.hi) begin n_err++; $display("FAIL div%0d_hi got %h want %h", i, hi, x.hi); end
      n_cmp++; if (lo !== x.lo) begin n_err++; $display("FAIL div%0d_lo got %h want %h", i, lo, x.lo); end
      tick();
    end
  endtask

  task automatic test_div_zero();
    exp_t e, x;
    int cyc;
    bit ok;
    issue(MTHI, 32'h1234, 32'd0, e);
    n_cmp++; if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi_hi got %h want 00001234", hi); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mthi_done got %b want 0", done); end
    issue(DIV, 32'hFFFF_FFF9, 32'd0, e);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL divzero_busy got %b want 0", busy); end
    wait_done(3, cyc, ok);
    n_cmp++; if (!ok || cyc != 0) begin n_err++; $display("FAIL divzero_done got cyc %0d (done=%b) want 0", cyc, done); end
    x = sb.pop_front();
    n_cmp++; if (hi !== x.hi) begin n_err++; $display("FAIL divzero_hi got %h want %h", hi, x.hi); end
    n_cmp++; if (lo !== x.lo) begin n_err++; $display("FAIL divzero_lo got %h want %h", lo, x.lo); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL divzero_after got done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_nop();
    exp_t e;
    issue(NOP, 32'hAAAA_5555, 32'd3, e);
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL nop_flags got busy=%b done=%b want 0/0", busy, done); end
    issue(RSVD, 32'hAAAA_5555, 32'd3, e);
    tick();
    n_cmp++; if (done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin n_err++; $display("FAIL rsvd_nop got done=%b hi=%h lo=%h want 0 %h %h", done, hi, lo, m_hi, m_lo); end
  endtask

  task automatic test_busy_enable();
    exp_t e, x;
    int cyc;
    bit ok;
    issue(MULTU, 32'd6, 32'd7, e);
    repeat (10) tick();
    start = 1'b1; op = MTLO; rs_val = 32'hDEAD;
    tick();
    start = 1'b0; clk_enable = 1'b0;
    repeat (5) tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL freeze_busy got %b want 1", busy); end
    clk_enable = 1'b1;
    wait_done(60, cyc, ok);
    cyc += 16;
    n_cmp++; if (!ok || cyc != 37) begin n_err++; $display("FAIL enable_latency got %0d (done=%b) want 37", cyc, done); end
    x = sb.pop_front();
    n_cmp++; if (lo !== x.lo) begin n_err++; $display("FAIL ignored_start_lo got %h want %h", lo, x.lo); end
    n_cmp++; if (hi !== x.hi) begin n_err++; $display("FAIL ignored_start_hi got %h want %h", hi, x.hi); end
    tick();
  endtask

  task automatic test_reset_midop();
    exp_t e, x;
    int cyc;
    bit ok, seen;
    issue(MULT, 32'hFFFF_FFF0, 32'h11, e);
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete(); m_hi = '0; m_lo = '0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midreset_flags got busy=%b done=%b want 0/0", busy, done); end
    n_cmp++; if (hi !== '0 || lo !== '0) begin n_err++; $display("FAIL midreset_hilo got %h/%h want 0/0", hi, lo); end
    seen = 1'b0;
    repeat (40) begin tick(); if (done === 1'b1) seen = 1'b1; end
    n_cmp++; if (seen) begin n_err++; $display("FAIL midreset_stale_done got 1 want 0"); end
    issue(MULTU, 32'd3, 32'd4, e);
    wait_done(100, cyc, ok);
    n_cmp++; if (!ok || cyc != 32) begin n_err++; $display("FAIL post_reset_latency got %0d want 32", cyc); end
    x = sb.pop_front();
    n_cmp++; if (lo !== x.lo || hi !== x.hi) begin n_err++; $display("FAIL post_reset_result got %h/%h want %h/%h", hi, lo, x.hi, x.lo); end
  endtask

  // Each next op is issued in the done cycle, i.e. accepted at the earliest legal edge.
  task automatic test_back_to_back();
    logic [2:0] ops [4] = '{MULT, MULTU, DIV, DIVU};
    logic [W-1:0] a, b;
    exp_t e, x;
    int cyc;
    bit ok;
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = (i == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
      issue(ops[i % 4], a, b, e);
      wait_done(40, cyc, ok);
      n_cmp++; if (!ok || cyc != e.lat) begin n_err++; $display("FAIL b2b%0d_latency got %0d (done=%b) want %0d", i, cyc, done, e.lat); end
      x = sb.pop_front();
      n_cmp++; if (hi !== x.hi || lo !== x.lo) begin n_err++; $display("FAIL b2b%0d_result op %0d got %h/%h want %h/%h", i, ops[i % 4], hi, lo, x.hi, x.lo); end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_nop();
    test_busy_enable();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
